// File: rtl/ebike_pkg.sv
// Shared types and constants for the e-bike pedal sequencing path.
package ebike_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SPINUP = 2'd1,
      PEDAL  = 2'd2,
      COAST  = 2'd3
   } state_t;

   localparam logic [15:0] MS_TICK_REAL = 16'd49999;
   localparam logic [15:0] MS_TICK_FAST = 16'd63;

   localparam logic [7:0] CAD_THR_FAST = 8'h10;
   localparam logic [7:0] CAD_THR_MID  = 8'h30;
   localparam logic [7:0] CAD_THR_SLOW = 8'h80;

   // Shorter period means faster pedalling, hence a higher level.
   function automatic logic [1:0] cad_quant(input logic [7:0] per);
      logic [1:0] lvl;
      if (per < CAD_THR_FAST) begin
         lvl = 2'd3;
      end else if (per < CAD_THR_MID) begin
         lvl = 2'd2;
      end else if (per < CAD_THR_SLOW) begin
         lvl = 2'd1;
      end else begin
         lvl = 2'd0;
      end
      return lvl;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler; held at zero while clr is high, free-runs otherwise.
module ms_tick_gen #(
   parameter bit FAST_SIM = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic ms_tick
);
   import ebike_pkg::*;

   localparam logic [15:0] TERM = FAST_SIM ? MS_TICK_FAST : MS_TICK_REAL;

   logic [15:0] presc_r;

   // Prescaler counter wrapping at TERM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= 16'd0;
      end else if (clr) begin
         presc_r <= 16'd0;
      end else if (presc_r == TERM) begin
         presc_r <= 16'd0;
      end else begin
         presc_r <= presc_r + 16'd1;
      end
   end

   assign ms_tick = ~clr & (presc_r == TERM);

endmodule

// File: rtl/pedal_seq_ctrl.sv
// Pedalling qualifier: spin-up qualification, coast hold-off, per-revolution
// sample strobe and quantised cadence level.
module pedal_seq_ctrl #(
   parameter bit          FAST_SIM     = 1'b0,
   parameter int unsigned SPINUP_EDGES = 32'd3,
   parameter logic [7:0]  COAST_MS     = 8'd200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cadence_filt,
   input  logic [7:0] cadence_per,
   input  logic       not_pedaling,
   output logic [1:0] state,
   output logic       pedaling,
   output logic       smpl_en,
   output logic [1:0] cad_lvl
);
   import ebike_pkg::*;

   localparam logic [2:0] SPIN_TGT = SPINUP_EDGES[2:0];

   state_t     state_r;
   logic       pedaling_r;
   logic       smpl_en_r;
   logic [1:0] cad_lvl_r;
   logic       cad_ff_r;
   logic [2:0] spin_cnt_r;
   logic [7:0] coast_cnt_r;
   logic       cad_rise_s;
   logic       ms_tick_s;
   logic       presc_clr_s;

   assign cad_rise_s  = cadence_filt & ~cad_ff_r;
   assign presc_clr_s = (state_r != COAST);

   ms_tick_gen #(
      .FAST_SIM (FAST_SIM)
   ) u_ms_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (presc_clr_s),
      .ms_tick (ms_tick_s)
   );

   // Delayed cadence level for rise detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cad_ff_r <= 1'b0;
      end else begin
         cad_ff_r <= cadence_filt;
      end
   end

   // Sequencer FSM with its registered outputs and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         pedaling_r  <= 1'b0;
         smpl_en_r   <= 1'b0;
         cad_lvl_r   <= 2'd0;
         spin_cnt_r  <= 3'd0;
         coast_cnt_r <= 8'd0;
      end else begin
         smpl_en_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cad_lvl_r <= 2'd0;
               if (cad_rise_s && !not_pedaling) begin
                  spin_cnt_r <= 3'd1;
                  if (SPIN_TGT == 3'd1) begin
                     state_r    <= PEDAL;
                     pedaling_r <= 1'b1;
                  end else begin
                     state_r    <= SPINUP;
                     pedaling_r <= 1'b0;
                  end
               end else begin
                  pedaling_r <= 1'b0;
               end
            end
            SPINUP: begin
               if (not_pedaling) begin
                  state_r    <= IDLE;
                  pedaling_r <= 1'b0;
                  spin_cnt_r <= 3'd0;
                  cad_lvl_r  <= 2'd0;
               end else if (cad_rise_s) begin
                  if (spin_cnt_r >= SPIN_TGT - 3'd1) begin
                     state_r    <= PEDAL;
                     pedaling_r <= 1'b1;
                     spin_cnt_r <= 3'd0;
                  end else if (spin_cnt_r != 3'd7) begin
                     spin_cnt_r <= spin_cnt_r + 3'd1;
                  end
               end
            end
            PEDAL: begin
               if (cad_rise_s) begin
                  smpl_en_r <= 1'b1;
                  cad_lvl_r <= cad_quant(cadence_per);
               end
               if (not_pedaling) begin
                  state_r     <= COAST;
                  coast_cnt_r <= COAST_MS;
               end
            end
            COAST: begin
               // A fresh rise resumes pedalling even on the terminal tick.
               if (cad_rise_s) begin
                  state_r   <= PEDAL;
                  smpl_en_r <= 1'b1;
               end else if (ms_tick_s) begin
                  if (coast_cnt_r <= 8'd1) begin
                     state_r     <= IDLE;
                     pedaling_r  <= 1'b0;
                     cad_lvl_r   <= 2'd0;
                     coast_cnt_r <= 8'd0;
                  end else begin
                     coast_cnt_r <= coast_cnt_r - 8'd1;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               pedaling_r  <= 1'b0;
               cad_lvl_r   <= 2'd0;
               spin_cnt_r  <= 3'd0;
               coast_cnt_r <= 8'd0;
            end
         endcase
      end
   end

   assign state    = state_r;
   assign pedaling = pedaling_r;
   assign smpl_en  = smpl_en_r;
   assign cad_lvl  = cad_lvl_r;

endmodule
